// File: rtl/lfsr16_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR generator/checker pair.
// Polynomial x^16 + x^14 + x^13 + x^11 + 1, shift-left, feedback into bit 0.
package lfsr16_pkg;

    localparam int LFSR_W = 16;

    // Feedback taps are state bits 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } checker_state_t;

    function automatic logic lfsr16_fb(input logic [LFSR_W-1:0] state);
        return ^(state & TAPS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a coincident increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr_i) begin
            count_next = '0;
        end else if (inc_i && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/lfsr16_checker.sv
// Receive-side LFSR checker: self-seeds from 16 stream bits, hunts for a run
// of correct predictions, then flywheels on its own predictions while locked.
module lfsr16_checker
    import lfsr16_pkg::*;
#(
    parameter int LOCK_MATCHES = 16,
    parameter int LOSS_ERRS    = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic [1:0]       state_o
);

    localparam logic [7:0] MATCH_LAST = 8'(LOCK_MATCHES - 1);
    localparam logic [3:0] MISS_LAST  = 4'(LOSS_ERRS - 1);

    logic [LFSR_W-1:0] s_reg, s_next;
    checker_state_t    state_reg, state_next;
    logic [3:0]        seed_cnt_reg, seed_cnt_next;
    logic [7:0]        match_cnt_reg, match_cnt_next;
    logic [3:0]        miss_cnt_reg, miss_cnt_next;
    logic              locked_reg, locked_next;
    logic              err_reg, err_next;

    logic              pred;
    logic              hit;
    logic [LFSR_W-1:0] shifted_rx;

    assign pred       = lfsr16_fb(s_reg);
    assign hit        = (pred == bit_i);
    assign shifted_rx = {s_reg[LFSR_W-2:0], bit_i};

    always_comb begin
        s_next         = s_reg;
        state_next     = state_reg;
        seed_cnt_next  = seed_cnt_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_next       = 1'b0;

        case (state_reg)
            SEED: begin
                if (valid_i) begin
                    s_next = shifted_rx;
                    if (seed_cnt_reg == 4'd15) begin
                        // An all-zero seed is a dead LFSR state; collect 16 fresh bits.
                        seed_cnt_next = 4'd0;
                        if (shifted_rx != '0) begin
                            state_next = HUNT;
                        end
                    end else begin
                        seed_cnt_next = seed_cnt_reg + 4'd1;
                    end
                end
            end

            HUNT: begin
                if (valid_i) begin
                    s_next = shifted_rx;
                    if (hit) begin
                        if (match_cnt_reg == MATCH_LAST) begin
                            state_next     = LOCKED;
                            match_cnt_next = 8'd0;
                        end else begin
                            match_cnt_next = match_cnt_reg + 8'd1;
                        end
                    end else begin
                        err_next       = 1'b1;
                        match_cnt_next = 8'd0;
                    end
                end
            end

            LOCKED: begin
                if (valid_i) begin
                    // Flywheel on the prediction so a corrupted bit cannot poison the state.
                    s_next = {s_reg[LFSR_W-2:0], pred};
                    if (hit) begin
                        miss_cnt_next = 4'd0;
                    end else begin
                        err_next = 1'b1;
                        if (miss_cnt_reg == MISS_LAST) begin
                            state_next    = SEED;
                            s_next        = '0;
                            seed_cnt_next = 4'd0;
                            miss_cnt_next = 4'd0;
                        end else begin
                            miss_cnt_next = miss_cnt_reg + 4'd1;
                        end
                    end
                end
            end

            default: begin
                state_next     = SEED;
                s_next         = '0;
                seed_cnt_next  = 4'd0;
                match_cnt_next = 8'd0;
                miss_cnt_next  = 4'd0;
            end
        endcase

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s_reg         <= '0;
            state_reg     <= SEED;
            seed_cnt_reg  <= 4'd0;
            match_cnt_reg <= 8'd0;
            miss_cnt_reg  <= 4'd0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            s_reg         <= s_next;
            state_reg     <= state_next;
            seed_cnt_reg  <= seed_cnt_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= locked_next;
            err_reg       <= err_next;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_count (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (err_next),
        .clr_i  (clear_i),
        .count_o(err_count_o)
    );

    assign locked_o = locked_reg;
    assign err_o    = err_reg;
    assign state_o  = state_reg;

endmodule
